// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave: FSM state encoding and frame command codes.
// Commands are the two MSBs of a frame; only the first one chooses write vs. read.
package spi_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_CHK_CMD   = 3'd1;
  localparam logic [2:0] ST_WRITE     = 3'd2;
  localparam logic [2:0] ST_READ_ADD  = 3'd3;
  localparam logic [2:0] ST_READ_DATA = 3'd4;
  localparam logic [2:0] ST_TX_WAIT   = 3'd5;
  localparam logic [2:0] ST_TX        = 3'd6;
  localparam logic [2:0] ST_WAIT_END  = 3'd7;

  localparam logic [1:0] CMD_WR0     = 2'b00;
  localparam logic [1:0] CMD_WR1     = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  // The first command bit separates reads from writes; the second is not decoded.
  function automatic logic cmd_is_read(input logic first_bit);
    return (first_bit == CMD_RD_ADDR[1]) && (first_bit != CMD_WR0[1]);
  endfunction

endpackage

// File: rtl/spi_tx_shift.sv
// Parallel-to-serial shifter for the read response: MSB is presented on the load edge,
// one lower bit per shift edge, then 0 once all DATA_W bits have been sent.
module spi_tx_shift #(
  parameter int DATA_W = 8,
  localparam int CNT_W = $clog2(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] data,
  output logic              miso,
  output logic              done
);

  logic [DATA_W-2:0] sh;
  logic [CNT_W-1:0]  cnt;

  assign done = (cnt == CNT_W'(DATA_W));

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      miso <= 1'b0;
      sh   <= '0;
      cnt  <= '0;
    end else if (load) begin
      miso <= data[DATA_W-1];
      sh   <= data[DATA_W-2:0];
      cnt  <= CNT_W'(1);
    end else if (shift) begin
      if (done) begin
        miso <= 1'b0;
      end else begin
        miso <= sh[DATA_W-2];
        sh   <= {sh[DATA_W-3:0], 1'b0};
        cnt  <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_slave_param.sv
// SPI slave clocked directly by clk: receives {cmd[1:0], payload} frames MSB first and
// answers a read-data frame with a DATA_W-bit response taken from tx_data.
module spi_slave_param
  import spi_pkg::*;
#(
  parameter int DATA_W = 8,
  localparam int FRAME_W = DATA_W + 2,
  localparam int CNT_W = $clog2(FRAME_W + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ss_n,
  input  logic               MOSI,
  input  logic [DATA_W-1:0]  tx_data,
  input  logic               tx_valid,
  output logic [FRAME_W-1:0] rx_data,
  output logic               rx_valid,
  output logic               MISO,
  output logic               frame_err,
  output logic               busy,
  output logic [2:0]         dbg_state,
  output logic               dbg_rd_pend
);

  // Handshake: tx_valid/tx_data form a one-sided valid with no ready; the payload is
  // taken on the first edge in TX_WAIT where tx_valid=1, and tx_valid is ignored elsewhere.

  logic [2:0]         state;
  logic [FRAME_W-2:0] shift_reg;
  logic [CNT_W-1:0]   bit_cnt;
  logic               rd_pend;
  logic               tx_load;
  logic               tx_step;
  logic               tx_done;

  assign busy        = (state != ST_IDLE);
  assign dbg_state   = state;
  assign dbg_rd_pend = rd_pend;
  assign tx_load     = (state == ST_TX_WAIT) && !ss_n && tx_valid;
  assign tx_step     = (state == ST_TX) && !ss_n;

  spi_tx_shift #(.DATA_W(DATA_W)) u_tx_shift (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (ss_n),
    .load  (tx_load),
    .shift (tx_step),
    .data  (tx_data),
    .miso  (MISO),
    .done  (tx_done)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      rd_pend   <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      if (state == ST_IDLE) begin
        bit_cnt <= '0;
        if (!ss_n) state <= ST_CHK_CMD;
      end else if (state == ST_WAIT_END) begin
        if (ss_n) begin
          state   <= ST_IDLE;
          bit_cnt <= '0;
        end
      end else if (ss_n) begin
        // Early deselect wins over everything, including a frame's final bit.
        state     <= ST_IDLE;
        bit_cnt   <= '0;
        frame_err <= 1'b1;
      end else begin
        unique case (state)
          ST_CHK_CMD: begin
            shift_reg <= {{(FRAME_W-2){1'b0}}, MOSI};
            bit_cnt   <= CNT_W'(1);
            if (!cmd_is_read(MOSI)) state <= ST_WRITE;
            else if (rd_pend)       state <= ST_READ_DATA;
            else                    state <= ST_READ_ADD;
          end
          ST_WRITE, ST_READ_ADD, ST_READ_DATA: begin
            shift_reg <= {shift_reg[FRAME_W-3:0], MOSI};
            bit_cnt   <= bit_cnt + 1'b1;
            if (bit_cnt == CNT_W'(FRAME_W - 1)) begin
              rx_data  <= {shift_reg, MOSI};
              rx_valid <= 1'b1;
              if (state == ST_READ_ADD) begin
                rd_pend <= 1'b1;
                state   <= ST_WAIT_END;
              end else if (state == ST_READ_DATA) begin
                rd_pend <= 1'b0;
                state   <= ST_TX_WAIT;
              end else begin
                state   <= ST_WAIT_END;
              end
            end
          end
          ST_TX_WAIT: if (tx_valid) state <= ST_TX;
          ST_TX:      if (tx_done) state <= ST_WAIT_END;
          default:    state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_param.sv
// Directed bench for spi_slave_param: 8-bit and 12-bit instances driven one step after
// each rising edge and checked at the same point with immediate assertions.
module tb_spi_slave_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        ss8, mosi8, txv8;
  logic [7:0]  txd8;
  logic [9:0]  rxd8;
  logic        rxv8, miso8, ferr8, busy8, rdp8;
  logic [2:0]  st8;

  logic        ss12, mosi12, txv12;
  logic [11:0] txd12;
  logic [13:0] rxd12;
  logic        rxv12, miso12, ferr12, busy12, rdp12;
  logic [2:0]  st12;

  int n_chk = 0;
  int n_fail = 0;
  int pulses;
  int miso_hi;
  logic [0:0] exp_q[$];

  spi_slave_param #(.DATA_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .ss_n(ss8), .MOSI(mosi8), .tx_data(txd8), .tx_valid(txv8),
    .rx_data(rxd8), .rx_valid(rxv8), .MISO(miso8), .frame_err(ferr8), .busy(busy8),
    .dbg_state(st8), .dbg_rd_pend(rdp8)
  );

  spi_slave_param #(.DATA_W(12)) dut12 (
    .clk(clk), .rst_n(rst_n), .ss_n(ss12), .MOSI(mosi12), .tx_data(txd12), .tx_valid(txv12),
    .rx_data(rxd12), .rx_valid(rxv12), .MISO(miso12), .frame_err(ferr12), .busy(busy12),
    .dbg_state(st12), .dbg_rd_pend(rdp12)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Select, then send nbits of f MSB first; tallies rx_valid pulses and MISO highs.
  task automatic frame8(input logic [9:0] f, input int nbits);
    ss8 = 1'b0;
    tick();
    pulses = 0;
    miso_hi = 0;
    for (int i = 0; i < nbits; i++) begin
      mosi8 = f[9-i];
      tick();
      if (rxv8) pulses++;
      if (miso8) miso_hi++;
    end
  endtask

  task automatic end8();
    ss8 = 1'b1;
    tick();
  endtask

  initial begin
    logic [13:0] f12;
    rst_n = 1'b0;
    ss8 = 1'b1; mosi8 = 1'b0; txv8 = 1'b0; txd8 = 8'h00;
    ss12 = 1'b1; mosi12 = 1'b0; txv12 = 1'b0; txd12 = 12'h000;
    tick();
    tick();
    chk("rst_rx_data", 32'(rxd8), 32'h0);
    chk("rst_rx_valid", 32'(rxv8), 32'h0);
    chk("rst_miso", 32'(miso8), 32'h0);
    chk("rst_frame_err", 32'(ferr8), 32'h0);
    chk("rst_busy", 32'(busy8), 32'h0);
    chk("rst_state", 32'(st8), 32'h0);
    chk("rst_rd_pend", 32'(rdp8), 32'h0);
    rst_n = 1'b1;
    tick();
    chk("idle_hold", 32'(st8), 32'h0);

    // Write frame 00_1010_0101
    frame8(10'b00_1010_0101, 10);
    chk("wr_rx_valid_last", 32'(rxv8), 32'h1);
    chk("wr_pulses", 32'(pulses), 32'h1);
    chk("wr_rx_data", 32'(rxd8), 32'h0A5);
    chk("wr_state", 32'(st8), 32'h7);
    tick();
    chk("wr_rx_valid_drop", 32'(rxv8), 32'h0);
    chk("wr_rx_data_hold", 32'(rxd8), 32'h0A5);
    end8();
    chk("wr_idle", 32'(st8), 32'h0);
    chk("wr_busy", 32'(busy8), 32'h0);

    // Read-address frame with tx_valid held high: MISO must stay 0
    txv8 = 1'b1; txd8 = 8'hFF;
    frame8(10'b10_0001_0000, 10);
    chk("ra_miso_quiet", 32'(miso_hi), 32'h0);
    chk("ra_rx_data", 32'(rxd8), 32'h210);
    chk("ra_pulses", 32'(pulses), 32'h1);
    chk("ra_rd_pend", 32'(rdp8), 32'h1);
    tick();
    chk("ra_miso_wait_end", 32'(miso8), 32'h0);
    end8();
    txv8 = 1'b0;
    chk("ra_rd_pend_kept", 32'(rdp8), 32'h1);

    // Read-data frame, then 0x3C response
    frame8(10'b11_0101_0101, 10);
    chk("rd_rx_data", 32'(rxd8), 32'h355);
    chk("rd_state", 32'(st8), 32'h5);
    chk("rd_rd_pend", 32'(rdp8), 32'h0);
    tick();
    chk("rd_tx_wait_hold", 32'(st8), 32'h5);
    chk("rd_tx_wait_miso", 32'(miso8), 32'h0);
    exp_q = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    txd8 = 8'h3C; txv8 = 1'b1;
    tick();
    txv8 = 1'b0; txd8 = 8'h00;
    chk("tx_state", 32'(st8), 32'h6);
    for (int i = 0; i < 9; i++) begin
      if (i > 0) tick();
      chk($sformatf("tx_miso_%0d", i), 32'(miso8), 32'(exp_q.pop_front()));
    end
    chk("tx_done_state", 32'(st8), 32'h7);
    tick();
    chk("tx_after_miso", 32'(miso8), 32'h0);
    end8();

    // Abort after 5 bits of a write frame
    frame8(10'b00_1111_0000, 5);
    ss8 = 1'b1;
    tick();
    if (rxv8) pulses++;
    chk("ab_frame_err", 32'(ferr8), 32'h1);
    chk("ab_state", 32'(st8), 32'h0);
    tick();
    chk("ab_frame_err_once", 32'(ferr8), 32'h0);
    chk("ab_rx_valid", 32'(pulses), 32'h0);
    chk("ab_rx_data", 32'(rxd8), 32'h355);

    // Deselect on the same edge as the final bit
    frame8(10'b01_1100_0011, 9);
    mosi8 = 1'b1; ss8 = 1'b1;
    tick();
    chk("ablast_frame_err", 32'(ferr8), 32'h1);
    chk("ablast_rx_valid", 32'(rxv8), 32'h0);
    chk("ablast_rx_data", 32'(rxd8), 32'h355);
    tick();

    // Reset in WAIT_END with rd_pend set
    frame8(10'b10_0000_0001, 10);
    chk("rsta_rd_pend_set", 32'(rdp8), 32'h1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; ss8 = 1'b1;
    chk("rsta_rd_pend", 32'(rdp8), 32'h0);
    chk("rsta_state", 32'(st8), 32'h0);
    tick();

    // Reset during TX bit 3 of an 0xFF response
    frame8(10'b10_0000_0010, 10);
    end8();
    frame8(10'b11_0000_0000, 10);
    txd8 = 8'hFF; txv8 = 1'b1;
    tick();
    txv8 = 1'b0;
    tick();
    tick();
    chk("rstb_miso_before", 32'(miso8), 32'h1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; ss8 = 1'b1;
    chk("rstb_miso", 32'(miso8), 32'h0);
    chk("rstb_state", 32'(st8), 32'h0);
    chk("rstb_rd_pend", 32'(rdp8), 32'h0);
    chk("rstb_frame_err", 32'(ferr8), 32'h0);
    tick();
    chk("rstb_frame_err_next", 32'(ferr8), 32'h0);

    // DATA_W=12 write frame 01_0xABC
    f12 = 14'h1ABC;
    ss12 = 1'b0;
    tick();
    pulses = 0;
    for (int i = 0; i < 14; i++) begin
      mosi12 = f12[13-i];
      tick();
      if (i < 13 && rxv12) pulses++;
    end
    chk("w12_early_valid", 32'(pulses), 32'h0);
    chk("w12_rx_valid", 32'(rxv12), 32'h1);
    chk("w12_rx_data", 32'(rxd12), 32'h1ABC);
    ss12 = 1'b1;
    tick();
    chk("w12_idle", 32'(st12), 32'h0);
    chk("w12_miso", 32'(miso12), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
